// File: rtl/prio_event_encoder.sv
// -----------------------------------------------------------------------------
// prio_event_encoder
//   Latches request pulses from N event lines into a pending register and
//   presents one pending index at a time on y/valid.
//   The index is held until the consumer acks it.
//   Arbitration is either fixed priority (index 0 highest, MODE=0) or
//   round-robin (MODE=1).
//
// Ports
//   clk       : single clock, rising edge
//   rst_n     : asynchronous active-low reset
//   en_n      : active-low enable; when high, new requests are masked
//   flush     : synchronous clear of pending, output and pointer state
//   req[N]    : request lines, sampled each edge while en_n=0
//   ack       : consumer accepts the current y (ignored while valid=0)
//   y[W]      : registered index of the granted request
//   valid     : registered, y holds a pending index
//   pending[N]: current pending register
//   overflow  : one-cycle pulse when a request hits an already-pending line
// -----------------------------------------------------------------------------
module prio_event_encoder #(
    parameter int N    = 8,
    parameter int W    = (N > 1) ? $clog2(N) : 1,
    parameter int MODE = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_n,
    input  logic         flush,
    input  logic [N-1:0] req,
    input  logic         ack,
    output logic [W-1:0] y,
    output logic         valid,
    output logic [N-1:0] pending,
    output logic         overflow
);

    logic [N-1:0] pend_r;
    logic [W-1:0] y_r;
    logic         valid_r;
    logic         overflow_r;
    logic [W-1:0] rr_ptr_r;

    logic [N-1:0] req_g_s;
    logic [N-1:0] clr_s;
    logic [N-1:0] cand_s;
    logic         take_s;
    logic [W-1:0] rr_next_s;
    logic [W-1:0] win_s;
    logic         ovf_s;

    // First set bit of v, scanning upward from start and wrapping N-1 -> 0.
    // The wrap is done with a subtract so non-power-of-two N never yields an
    // index >= N.
    function automatic logic [W-1:0] winner(input logic [N-1:0] v,
                                            input logic [W-1:0] start);
        logic [W-1:0] r;
        logic         found;
        int           idx;
        r     = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(start) + k;
            if (idx >= N) begin
                idx = idx - N;
            end else begin
                idx = idx;
            end
            if (!found && v[idx]) begin
                r     = W'(idx);
                found = 1'b1;
            end else begin
                r     = r;
            end
        end
        return r;
    endfunction

    // Candidate set, round-robin pointer update and winner selection for this edge.
    always_comb begin
        req_g_s   = en_n ? '0 : req;
        take_s    = valid_r && ack;
        clr_s     = '0;
        rr_next_s = rr_ptr_r;
        if (take_s) begin
            clr_s[y_r] = 1'b1;
        end else begin
            clr_s = '0;
        end
        // The pointer moves past the index being acked on this very edge, and
        // the reload below already searches from the moved pointer; otherwise
        // a re-asserted line would win twice in a row.
        if ((MODE == 1) && take_s) begin
            rr_next_s = (y_r == W'(N - 1)) ? '0 : (y_r + W'(1));
        end else begin
            rr_next_s = rr_ptr_r;
        end
        cand_s = (pend_r & ~clr_s) | req_g_s;
        ovf_s  = |(req_g_s & pend_r & ~clr_s);
        if (MODE == 1) begin
            win_s = winner(cand_s, rr_next_s);
        end else begin
            win_s = winner(cand_s, '0);
        end
    end

    // State registers: async reset, flush as synchronous clear, then normal update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r     <= '0;
            y_r        <= '0;
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
            rr_ptr_r   <= '0;
        end else if (flush) begin
            pend_r     <= '0;
            y_r        <= '0;
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
            rr_ptr_r   <= '0;
        end else begin
            pend_r     <= cand_s;
            overflow_r <= ovf_s;
            rr_ptr_r   <= rr_next_s;
            // The output slot only reloads when empty or being consumed.
            if (!valid_r || ack) begin
                valid_r <= |cand_s;
                y_r     <= (|cand_s) ? win_s : '0;
            end else begin
                valid_r <= valid_r;
                y_r     <= y_r;
            end
        end
    end

    assign y        = y_r;
    assign valid    = valid_r;
    assign pending  = pend_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_prio_event_encoder.sv
// -----------------------------------------------------------------------------
// tb_prio_event_encoder
//   Directed bench with two instances: N=8 fixed priority (u_fix) and
//   N=5 round-robin (u_rr).
//   Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_prio_event_encoder;

    logic       clk;
    logic       rst_n;

    logic       en_n_a, flush_a, ack_a;
    logic [7:0] req_a;
    logic [2:0] y_a;
    logic       valid_a, overflow_a;
    logic [7:0] pending_a;

    logic       en_n_b, flush_b, ack_b;
    logic [4:0] req_b;
    logic [2:0] y_b;
    logic       valid_b, overflow_b;
    logic [4:0] pending_b;

    int n_vec;
    int n_err;

    prio_event_encoder #(.N(8), .MODE(0)) u_fix (
        .clk(clk), .rst_n(rst_n), .en_n(en_n_a), .flush(flush_a),
        .req(req_a), .ack(ack_a), .y(y_a), .valid(valid_a),
        .pending(pending_a), .overflow(overflow_a)
    );

    prio_event_encoder #(.N(5), .MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .en_n(en_n_b), .flush(flush_b),
        .req(req_b), .ack(ack_b), .y(y_b), .valid(valid_b),
        .pending(pending_b), .overflow(overflow_b)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int exp_seq[6] = '{1, 2, 3, 4, 0, 1};

    // Directed stimulus.
    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        en_n_a = 1'b0; flush_a = 1'b0; ack_a = 1'b0; req_a = 8'h00;
        en_n_b = 1'b0; flush_b = 1'b0; ack_b = 1'b0; req_b = 5'h00;
        #12;
        check_val("rst_valid", 32'(valid_a), 32'd0);
        check_val("rst_y", 32'(y_a), 32'd0);
        check_val("rst_pend", 32'(pending_a), 32'd0);
        check_val("rst_ovf", 32'(overflow_a), 32'd0);
        rst_n = 1'b1;
        step();

        // T1: fixed priority drain of 0xA0.
        req_a = 8'hA0; step(); req_a = 8'h00;
        check_val("t1_valid", 32'(valid_a), 32'd1);
        check_val("t1_y5", 32'(y_a), 32'd5);
        check_val("t1_pend", 32'(pending_a), 32'hA0);
        ack_a = 1'b1; step();
        check_val("t1_y7", 32'(y_a), 32'd7);
        check_val("t1_pend80", 32'(pending_a), 32'h80);
        step(); ack_a = 1'b0;
        check_val("t1_empty_valid", 32'(valid_a), 32'd0);
        check_val("t1_empty_y", 32'(y_a), 32'd0);

        // T2: y held while not acked; newly pending bit wins afterwards.
        req_a = 8'h20; step(); req_a = 8'h00;
        check_val("t2_y5", 32'(y_a), 32'd5);
        req_a = 8'h02; step(); req_a = 8'h00;
        check_val("t2_hold_y", 32'(y_a), 32'd5);
        check_val("t2_pend", 32'(pending_a), 32'h22);
        step();
        check_val("t2_hold_y2", 32'(y_a), 32'd5);
        ack_a = 1'b1; step(); ack_a = 1'b0;
        check_val("t2_y1", 32'(y_a), 32'd1);
        check_val("t2_pend2", 32'(pending_a), 32'h02);
        ack_a = 1'b1; step(); ack_a = 1'b0;
        check_val("t2_empty", 32'(valid_a), 32'd0);

        // T4: enable masking, existing pending still drains.
        en_n_a = 1'b1; req_a = 8'hFF; step(); step();
        check_val("t4_mask_pend", 32'(pending_a), 32'h00);
        check_val("t4_mask_valid", 32'(valid_a), 32'd0);
        en_n_a = 1'b0; req_a = 8'h09; step(); req_a = 8'hFF; en_n_a = 1'b1;
        check_val("t4_y0", 32'(y_a), 32'd0);
        check_val("t4_pend09", 32'(pending_a), 32'h09);
        ack_a = 1'b1; step();
        check_val("t4_y3", 32'(y_a), 32'd3);
        check_val("t4_pend08", 32'(pending_a), 32'h08);
        step(); ack_a = 1'b0;
        check_val("t4_drained", 32'(valid_a), 32'd0);
        check_val("t4_drained_p", 32'(pending_a), 32'h00);
        en_n_a = 1'b0; req_a = 8'h00;

        // T5: overflow pulse and same-edge re-request.
        req_a = 8'h08; step(); req_a = 8'h00;
        check_val("t5_y3", 32'(y_a), 32'd3);
        check_val("t5_no_ovf", 32'(overflow_a), 32'd0);
        req_a = 8'h08; step(); req_a = 8'h00;
        check_val("t5_ovf", 32'(overflow_a), 32'd1);
        step();
        check_val("t5_ovf_1cyc", 32'(overflow_a), 32'd0);
        ack_a = 1'b1; req_a = 8'h08; step(); ack_a = 1'b0; req_a = 8'h00;
        check_val("t5_reack_ovf", 32'(overflow_a), 32'd0);
        check_val("t5_reack_pend", 32'(pending_a), 32'h08);
        check_val("t5_reack_y", 32'(y_a), 32'd3);
        check_val("t5_reack_valid", 32'(valid_a), 32'd1);
        ack_a = 1'b1; step(); ack_a = 1'b0;
        check_val("t5_empty", 32'(valid_a), 32'd0);

        // T3: round-robin, all lines held, ack every cycle.
        req_b = 5'h1F; ack_b = 1'b1; step();
        check_val("t3_y_first", 32'(y_b), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check_val($sformatf("t3_y_%0d", i), 32'(y_b), 32'(exp_seq[i]));
            check_val($sformatf("t3_v_%0d", i), 32'(valid_b), 32'd1);
        end
        req_b = 5'h00; ack_b = 1'b0;

        // T6: flush clears everything including the round-robin pointer.
        flush_b = 1'b1; step(); flush_b = 1'b0;
        check_val("t6_rr_flush_v", 32'(valid_b), 32'd0);
        check_val("t6_rr_flush_p", 32'(pending_b), 32'h00);
        req_b = 5'h1F; step(); req_b = 5'h00;
        check_val("t6_rr_ptr0", 32'(y_b), 32'd0);

        req_a = 8'hFF; step(); req_a = 8'h00;
        check_val("t6_full_pend", 32'(pending_a), 32'hFF);
        flush_a = 1'b1; ack_a = 1'b1; req_a = 8'h01; step();
        flush_a = 1'b0; ack_a = 1'b0; req_a = 8'h00;
        check_val("t6_flush_pend", 32'(pending_a), 32'h00);
        check_val("t6_flush_valid", 32'(valid_a), 32'd0);
        check_val("t6_flush_y", 32'(y_a), 32'd0);
        check_val("t6_flush_ovf", 32'(overflow_a), 32'd0);

        // T6: asynchronous reset in the middle of a handshake.
        req_a = 8'h04; step(); req_a = 8'h00;
        check_val("t6_pre_y", 32'(y_a), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check_val("t6_async_valid", 32'(valid_a), 32'd0);
        check_val("t6_async_y", 32'(y_a), 32'd0);
        check_val("t6_async_pend", 32'(pending_a), 32'h00);
        #3 rst_n = 1'b1;
        step();
        check_val("t6_after_rst", 32'(valid_a), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
